// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and external bus signals seen by the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);
  localparam int unsigned BEW = XLEN / 8;

  logic            i_I_req;
  logic [XLEN-1:0] i_I_addr;
  logic            i_I_kill;
  logic [XLEN-1:0] o_I_rdata;
  logic            o_I_valid;

  logic            i_D_req;
  logic            i_D_we;
  logic [BEW-1:0]  i_D_be;
  logic [XLEN-1:0] i_D_addr;
  logic [XLEN-1:0] i_D_wdata;
  logic [XLEN-1:0] o_D_rdata;
  logic            o_D_valid;

  logic            o_BUS_req;
  logic            o_BUS_we;
  logic [BEW-1:0]  o_BUS_be;
  logic [XLEN-1:0] o_BUS_addr;
  logic [XLEN-1:0] o_BUS_wdata;
  logic            i_BUS_gnt;
  logic            i_BUS_rvalid;
  logic [XLEN-1:0] i_BUS_rdata;

  // Arbiter side
  modport slave (
    input  i_I_req, i_I_addr, i_I_kill,
    input  i_D_req, i_D_we, i_D_be, i_D_addr, i_D_wdata,
    input  i_BUS_gnt, i_BUS_rvalid, i_BUS_rdata,
    output o_I_rdata, o_I_valid, o_D_rdata, o_D_valid,
    output o_BUS_req, o_BUS_we, o_BUS_be, o_BUS_addr, o_BUS_wdata
  );

  // Core pipeline and memory side
  modport master (
    output i_I_req, i_I_addr, i_I_kill,
    output i_D_req, i_D_we, i_D_be, i_D_addr, i_D_wdata,
    output i_BUS_gnt, i_BUS_rvalid, i_BUS_rdata,
    input  o_I_rdata, o_I_valid, o_D_rdata, o_D_valid,
    input  o_BUS_req, o_BUS_we, o_BUS_be, o_BUS_addr, o_BUS_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-requester picker: fixed data priority or round-robin on the last launched port.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_FIXED
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_req,
  input  logic data_req,
  input  logic launch,
  output logic pick_data_c,
  output logic pick_any_c
);

  logic last_data;

  // On a tie the port that was not launched last wins in round-robin mode
  always_comb begin
    pick_any_c  = fetch_req | data_req;
    pick_data_c = data_req;
    if (fetch_req && data_req && (ARB_MODE == ARB_RR)) begin
      pick_data_c = ~last_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data <= 1'b0;
    end else if (launch) begin
      last_data <= pick_data_c;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory bus between the fetch port and the data port,
// one transaction at a time, dropping fetch responses killed by a flush.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned ARB_MODE = ARB_FIXED
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned BEW = XLEN / 8;

  arb_state_e      state_q, state_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [BEW-1:0]  bus_be_q, bus_be_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  logic            win_data_q, win_data_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] i_rdata_q, i_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            launch, pick_data_c, pick_any_c, kill_hit, d_resp;

  // A fetch is never launched while a flush is being signalled
  mem_arb_pick #(.ARB_MODE(ARB_MODE)) u_pick (
    .clk         (i_clk),
    .rst         (i_rst),
    .fetch_req   (bus.i_I_req & ~bus.i_I_kill),
    .data_req    (bus.i_D_req),
    .launch      (launch),
    .pick_data_c (pick_data_c),
    .pick_any_c  (pick_any_c)
  );

  assign kill_hit = bus.i_I_kill & ~win_data_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      win_data_q  <= 1'b0;
      kill_q      <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      win_data_q  <= win_data_d;
      kill_q      <= kill_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    win_data_d  = win_data_q;
    kill_d      = kill_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    launch      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          launch     = 1'b1;
          win_data_d = pick_data_c;
          bus_req_d  = 1'b1;
          state_d    = ST_REQ;
          if (pick_data_c) begin
            bus_we_d    = bus.i_D_we;
            bus_be_d    = bus.i_D_be;
            bus_addr_d  = bus.i_D_addr;
            bus_wdata_d = bus.i_D_wdata;
          end else begin
            bus_we_d    = 1'b0;
            bus_be_d    = '1;
            bus_addr_d  = bus.i_I_addr;
            bus_wdata_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (kill_hit) kill_d = 1'b1;
        if (bus.i_BUS_gnt) begin
          bus_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (kill_hit) kill_d = 1'b1;
        // A killed fetch still finishes on the bus but its data is dropped
        if (bus.i_BUS_rvalid) begin
          state_d = ST_RESP;
          if (win_data_q) begin
            d_rdata_d = bus.i_BUS_rdata;
          end else if (!kill_q && !bus.i_I_kill) begin
            i_rdata_d = bus.i_BUS_rdata;
          end
        end
      end
      ST_RESP: begin
        kill_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion strobes come straight from the RESP state so a late flush still suppresses them
  assign d_resp        = (state_q == ST_RESP) & win_data_q;
  assign bus.o_I_valid = (state_q == ST_RESP) & ~win_data_q & ~kill_q & ~bus.i_I_kill;
  assign bus.o_D_valid = ~bus.i_D_req | d_resp;

  assign bus.o_I_rdata   = i_rdata_q;
  assign bus.o_D_rdata   = d_rdata_q;
  assign bus.o_BUS_req   = bus_req_q;
  assign bus.o_BUS_we    = bus_we_q;
  assign bus.o_BUS_be    = bus_be_q;
  assign bus.o_BUS_addr  = bus_addr_q;
  assign bus.o_BUS_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter; a fixed-priority and a round-robin
// instance share the same stimulus.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s_ireq, s_ikill, s_dreq, s_dwe, s_gnt, s_rv;
  logic [31:0] s_iaddr, s_daddr, s_dwdata, s_rdata;
  logic [3:0]  s_dbe;

  mem_arbiter_if #(.XLEN(XLEN)) if0 ();
  mem_arbiter_if #(.XLEN(XLEN)) if1 ();

  assign if0.i_I_req = s_ireq;   assign if1.i_I_req = s_ireq;
  assign if0.i_I_addr = s_iaddr; assign if1.i_I_addr = s_iaddr;
  assign if0.i_I_kill = s_ikill; assign if1.i_I_kill = s_ikill;
  assign if0.i_D_req = s_dreq;   assign if1.i_D_req = s_dreq;
  assign if0.i_D_we = s_dwe;     assign if1.i_D_we = s_dwe;
  assign if0.i_D_be = s_dbe;     assign if1.i_D_be = s_dbe;
  assign if0.i_D_addr = s_daddr; assign if1.i_D_addr = s_daddr;
  assign if0.i_D_wdata = s_dwdata; assign if1.i_D_wdata = s_dwdata;
  assign if0.i_BUS_gnt = s_gnt;  assign if1.i_BUS_gnt = s_gnt;
  assign if0.i_BUS_rvalid = s_rv; assign if1.i_BUS_rvalid = s_rv;
  assign if0.i_BUS_rdata = s_rdata; assign if1.i_BUS_rdata = s_rdata;

  mem_arbiter #(.XLEN(XLEN), .ARB_MODE(ARB_FIXED)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
  mem_arbiter #(.XLEN(XLEN), .ARB_MODE(ARB_RR))    dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));

  typedef struct packed {
    logic        ireq;   logic [31:0] iaddr;  logic ikill;
    logic        dreq;   logic dwe; logic [3:0] dbe; logic [31:0] daddr; logic [31:0] dwdata;
    logic        gnt;    logic rv;  logic [31:0] rdata;
    logic        e_breq; logic chk_bus; logic e_bwe; logic [3:0] e_bbe;
    logic [31:0] e_baddr; logic [31:0] e_bwdata;
    logic        e_iv;   logic [31:0] e_ird;
    logic        e_dv;   logic [31:0] e_drd;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic add(input vec_t v);
    vq.push_back(v);
  endtask

  task automatic set_idle();
    s_ireq = 1'b0; s_iaddr = '0; s_ikill = 1'b0;
    s_dreq = 1'b0; s_dwe = 1'b0; s_dbe = '0; s_daddr = '0; s_dwdata = '0;
    s_gnt = 1'b0; s_rv = 1'b0; s_rdata = '0;
  endtask

  task automatic drive(input vec_t v);
    s_ireq = v.ireq; s_iaddr = v.iaddr; s_ikill = v.ikill;
    s_dreq = v.dreq; s_dwe = v.dwe; s_dbe = v.dbe; s_daddr = v.daddr; s_dwdata = v.dwdata;
    s_gnt = v.gnt; s_rv = v.rv; s_rdata = v.rdata;
  endtask

  task automatic check_row(input int i, input vec_t v);
    string p;
    p = $sformatf("row%0d ", i);
    chk({p, "bus_req"}, 32'(if0.o_BUS_req), 32'(v.e_breq));
    chk({p, "I_valid"}, 32'(if0.o_I_valid), 32'(v.e_iv));
    chk({p, "I_rdata"}, if0.o_I_rdata, v.e_ird);
    chk({p, "D_valid"}, 32'(if0.o_D_valid), 32'(v.e_dv));
    chk({p, "D_rdata"}, if0.o_D_rdata, v.e_drd);
    if (v.chk_bus) begin
      chk({p, "bus_we"}, 32'(if0.o_BUS_we), 32'(v.e_bwe));
      chk({p, "bus_be"}, 32'(if0.o_BUS_be), 32'(v.e_bbe));
      chk({p, "bus_addr"}, if0.o_BUS_addr, v.e_baddr);
      chk({p, "bus_wdata"}, if0.o_BUS_wdata, v.e_bwdata);
    end
  endtask

  task automatic run_rows();
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i]);
      @(negedge clk);
      check_row(i, vq[i]);
    end
    vq.delete();
  endtask

  initial begin
    int n0, n1;
    logic exp_d;
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset bus_req", 32'(if0.o_BUS_req), 32'd0);
    chk("reset I_valid", 32'(if0.o_I_valid), 32'd0);
    chk("reset D_valid", 32'(if0.o_D_valid), 32'd1);
    chk("reset rr D_valid", 32'(if1.o_D_valid), 32'd1);
    chk("reset bus_addr", if0.o_BUS_addr, 32'd0);
    rst = 1'b0;

    // Lone fetch 0x100: 3-cycle latency
    add('{1'b1,32'h100,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0, 1'b1,32'h0});
    add('{1'b1,32'h100,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0,  1'b1,1'b1,1'b0,4'hF,32'h100,32'h0, 1'b0,32'h0, 1'b1,32'h0});
    add('{1'b1,32'h100,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'h13, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0, 1'b1,32'h0});
    add('{1'b1,32'h100,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,32'h13, 1'b1,32'h0});
    add('{1'b0,32'h0,1'b0,   1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h13, 1'b1,32'h0});
    // Tie: D load 0x200 wins, then I fetch 0x300
    add('{1'b1,32'h300,1'b0, 1'b1,1'b0,4'hF,32'h200,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h13, 1'b0,32'h0});
    add('{1'b1,32'h300,1'b0, 1'b1,1'b0,4'hF,32'h200,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,4'hF,32'h200,32'h0, 1'b0,32'h13, 1'b0,32'h0});
    add('{1'b1,32'h300,1'b0, 1'b1,1'b0,4'hF,32'h200,32'h0, 1'b0,1'b1,32'hAAAA5555, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h13, 1'b0,32'h0});
    add('{1'b1,32'h300,1'b0, 1'b1,1'b0,4'hF,32'h200,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h13, 1'b1,32'hAAAA5555});
    add('{1'b1,32'h300,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h13, 1'b1,32'hAAAA5555});
    add('{1'b1,32'h300,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0,   1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,4'hF,32'h300,32'h0, 1'b0,32'h13, 1'b1,32'hAAAA5555});
    add('{1'b1,32'h300,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,1'b1,32'h00500093, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h13, 1'b1,32'hAAAA5555});
    add('{1'b1,32'h300,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,32'h00500093, 1'b1,32'hAAAA5555});
    add('{1'b0,32'h0,1'b0,   1'b0,1'b0,4'h0,32'h0,32'h0,   1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b1,32'hAAAA5555});
    // Store be=0011 with gnt held off for three REQ cycles
    add('{1'b0,32'h0,1'b0, 1'b1,1'b1,4'h3,32'h400,32'hDEADBEEF, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b0,32'hAAAA5555});
    for (int k = 0; k < 3; k++)
      add('{1'b0,32'h0,1'b0, 1'b1,1'b1,4'h3,32'h400,32'hDEADBEEF, 1'b0,1'b0,32'h0, 1'b1,1'b1,1'b1,4'h3,32'h400,32'hDEADBEEF, 1'b0,32'h00500093, 1'b0,32'hAAAA5555});
    add('{1'b0,32'h0,1'b0, 1'b1,1'b1,4'h3,32'h400,32'hDEADBEEF, 1'b1,1'b0,32'h0, 1'b1,1'b1,1'b1,4'h3,32'h400,32'hDEADBEEF, 1'b0,32'h00500093, 1'b0,32'hAAAA5555});
    add('{1'b0,32'h0,1'b0, 1'b1,1'b1,4'h3,32'h400,32'hDEADBEEF, 1'b0,1'b1,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b0,32'hAAAA5555});
    add('{1'b0,32'h0,1'b0, 1'b1,1'b1,4'h3,32'h400,32'hDEADBEEF, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    add('{1'b0,32'h0,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    // Kill in IDLE blocks launch; kill in WAIT drops response; next fetch 0x104 normal
    add('{1'b1,32'h108,1'b1, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    add('{1'b1,32'h108,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    add('{1'b1,32'h108,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,4'hF,32'h108,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    add('{1'b0,32'h0,1'b1,   1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    add('{1'b0,32'h0,1'b0,   1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'hBAD, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    add('{1'b0,32'h0,1'b0,   1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    add('{1'b1,32'h104,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    add('{1'b1,32'h104,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,4'hF,32'h104,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    add('{1'b1,32'h104,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'h517, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h00500093, 1'b1,32'h0});
    add('{1'b1,32'h104,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,32'h517, 1'b1,32'h0});
    add('{1'b0,32'h0,1'b0,   1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h517, 1'b1,32'h0});
    run_rows();

    // Both ports held with an always-ready bus: fixed mode serves D only, RR alternates D,I,D,I
    @(posedge clk); #1;
    s_ireq = 1'b1; s_iaddr = 32'h500; s_dreq = 1'b1; s_dwe = 1'b0; s_dbe = 4'hF; s_daddr = 32'h600;
    s_gnt = 1'b1; s_rv = 1'b1; s_rdata = 32'h11;
    n0 = 0; n1 = 0; exp_d = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (if0.o_BUS_req) begin
        n0++;
        chk("fixed grant addr", if0.o_BUS_addr, 32'h600);
      end
      if (if1.o_BUS_req) begin
        n1++;
        chk("rr grant addr", if1.o_BUS_addr, exp_d ? 32'h600 : 32'h500);
        exp_d = ~exp_d;
      end
      if (if1.o_I_valid && if1.o_D_valid) begin
        chk("rr strobe overlap", 32'd1, 32'd0);
      end
    end
    chk("fixed grant count", 32'(n0), 32'd4);
    chk("rr grant count", 32'(n1), 32'd4);
    @(posedge clk); #1;
    s_ireq = 1'b0; s_dreq = 1'b0;
    repeat (3) @(posedge clk);
    #1 set_idle();

    // Complete fetch 0x700, then launch 0x704 up to its grant
    add('{1'b1,32'h700,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h517, 1'b1,32'h11});
    add('{1'b1,32'h700,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,4'hF,32'h700,32'h0, 1'b0,32'h517, 1'b1,32'h11});
    add('{1'b1,32'h700,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'hCAFE0013, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h517, 1'b1,32'h11});
    add('{1'b1,32'h700,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,32'hCAFE0013, 1'b1,32'h11});
    add('{1'b1,32'h704,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'hCAFE0013, 1'b1,32'h11});
    add('{1'b1,32'h704,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,4'hF,32'h704,32'h0, 1'b0,32'hCAFE0013, 1'b1,32'h11});
    run_rows();

    // Async reset in WAIT: outputs return to reset values without a clock edge
    @(posedge clk); #1;
    s_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst bus_req", 32'(if0.o_BUS_req), 32'd0);
    chk("rst bus_we", 32'(if0.o_BUS_we), 32'd0);
    chk("rst bus_be", 32'(if0.o_BUS_be), 32'd0);
    chk("rst bus_addr", if0.o_BUS_addr, 32'd0);
    chk("rst I_rdata", if0.o_I_rdata, 32'd0);
    chk("rst D_rdata", if0.o_D_rdata, 32'd0);
    chk("rst I_valid", 32'(if0.o_I_valid), 32'd0);
    chk("rst D_valid", 32'(if0.o_D_valid), 32'd1);
    s_ireq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    s_rv = 1'b1; s_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray bus_req", 32'(if0.o_BUS_req), 32'd0);
    chk("stray I_valid", 32'(if0.o_I_valid), 32'd0);
    @(posedge clk); #1;
    s_rv = 1'b0; s_rdata = '0;
    @(negedge clk);
    chk("stray I_rdata", if0.o_I_rdata, 32'd0);
    chk("stray bus_req2", 32'(if0.o_BUS_req), 32'd0);

    // Post-reset fetch 0x708 keeps the minimum latency
    add('{1'b1,32'h708,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0, 1'b1,32'h0});
    add('{1'b1,32'h708,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,4'hF,32'h708,32'h0, 1'b0,32'h0, 1'b1,32'h0});
    add('{1'b1,32'h708,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'h297, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0, 1'b1,32'h0});
    add('{1'b1,32'h708,1'b0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,32'h297, 1'b1,32'h0});
    add('{1'b0,32'h0,1'b0,   1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h297, 1'b1,32'h0});
    run_rows();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
